// File: rtl/sr_latch_driver_if.sv
// Request/drive bundle between a controller and sr_latch_driver.
// master: requester side (also supplies latch q feedback); slave: the driver.
interface sr_latch_driver_if;
  logic set_req;
  logic clr_req;
  logic q_fb;
  logic s;
  logic r;
  logic en;
  logic busy;
  logic done;
  logic conflict;
  logic err;

  modport master (
    output set_req, clr_req, q_fb,
    input  s, r, en, busy, done, conflict, err
  );

  modport slave (
    input  set_req, clr_req, q_fb,
    output s, r, en, busy, done, conflict, err
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Sequences setup/pulse/hold timing for a downstream gated SR latch.
// Optional readback check of q_fb at completion is enabled by macro SR_DRV_VERIFY_EN.
module sr_latch_driver #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic             clk,
  input logic             rst,
  sr_latch_driver_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  // Counters load length-1 so a phase ends when the count reaches zero.
  localparam logic [3:0] SetupLd = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PulseLd = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HoldLd  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       conflict_q, conflict_d;

  logic one_req;
  logic both_req;
  logic phase_end;

  assign one_req   = bus.set_req ^ bus.clr_req;
  assign both_req  = bus.set_req & bus.clr_req;
  assign phase_end = (cnt_q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (one_req) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (phase_end) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPulse: begin
        if (phase_end) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drive values are registered; s/r only move in IDLE and at the HOLD exit, never with en high.
  always_comb begin
    s_d        = s_q;
    r_d        = r_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    conflict_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (one_req) begin
          s_d    = bus.set_req;
          r_d    = bus.clr_req;
          busy_d = 1'b1;
        end else if (both_req) begin
          conflict_d = 1'b1;
        end
      end
      StSetup: begin
        if (phase_end) en_d = 1'b1;
      end
      StPulse: begin
        if (phase_end) en_d = 1'b0;
      end
      StHold: begin
        if (phase_end) begin
          s_d    = 1'b0;
          r_d    = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        s_d    = 1'b0;
        r_d    = 1'b0;
        en_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

`ifdef SR_DRV_VERIFY_EN
  logic err_q, err_d;

  // s_q still holds the commanded value at the done edge.
  always_comb begin
    err_d = err_q;
    if ((state_q == StHold) && phase_end && (bus.q_fb != s_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = bus.q_fb;
  assign bus.err     = 1'b0;
`endif

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.en       = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default-timing instance plus a 3/1/2 timing instance.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_latch_driver_if ifa ();
  sr_latch_driver_if ifb ();

  sr_latch_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sr_latch_driver #(
    .SETUP_CYC (3),
    .PULSE_CYC (1),
    .HOLD_CYC  (2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int   checks   = 0;
  int   failures = 0;
  logic bad_fb   = 1'b0;
  logic q_model  = 1'b0;
  logic exp_err  = 1'b0;

  // Behavioural gated SR latch behind dut; dut2 only ever sets, so its feedback reads 1.
  always @(posedge clk) begin
    if (ifa.en) begin
      if (ifa.s)      q_model <= 1'b1;
      else if (ifa.r) q_model <= 1'b0;
    end
  end
  assign ifa.q_fb = bad_fb ? 1'b0 : q_model;
  assign ifb.q_fb = 1'b1;

  logic [6:0] va, vb;
  assign va = {ifa.s, ifa.r, ifa.en, ifa.busy, ifa.done, ifa.conflict, ifa.err};
  assign vb = {ifb.s, ifb.r, ifb.en, ifb.busy, ifb.done, ifb.conflict, ifb.err};

  // Invariants at each falling edge: s&r never both high, s/r frozen around any en-high sample.
  logic       prev_rst = 1'b1;
  logic       pa_en, pb_en;
  logic [1:0] pa_sr, pb_sr;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      checks++;
      assert (!(ifa.s && ifa.r) && (!(ifa.en || pa_en) || ({ifa.s, ifa.r} === pa_sr))) else begin
        failures++;
        $error("FAIL inv_a observed s=%b r=%b en=%b prev_sr=%b required no overlap/no change",
               ifa.s, ifa.r, ifa.en, pa_sr);
      end
      checks++;
      assert (!(ifb.s && ifb.r) && (!(ifb.en || pb_en) || ({ifb.s, ifb.r} === pb_sr))) else begin
        failures++;
        $error("FAIL inv_b observed s=%b r=%b en=%b prev_sr=%b required no overlap/no change",
               ifb.s, ifb.r, ifb.en, pb_sr);
      end
    end
    prev_rst = rst;
    pa_en    = ifa.en;
    pa_sr    = {ifa.s, ifa.r};
    pb_en    = ifb.en;
    pb_sr    = {ifb.s, ifb.r};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed {s,r,en,busy,done,conf,err}=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ev(input logic s, input logic r, input logic en,
                                    input logic busy, input logic done, input logic conf);
    return {s, r, en, busy, done, conf, exp_err};
  endfunction

  // One command on dut at default timing: edges 0..4 plus an idle edge.
  // noise raises the opposite request during edges 0..3; bad pulls q_fb low for the command.
  task automatic run_cmd(input string tag, input logic is_set, input logic noise,
                         input logic bad);
    bad_fb = bad;
    if (is_set) ifa.set_req = 1'b1;
    else        ifa.clr_req = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      if (i == 0) begin
        ifa.set_req = 1'b0;
        ifa.clr_req = 1'b0;
      end
`ifdef SR_DRV_VERIFY_EN
      if (bad && i == 4) exp_err = 1'b1;
`endif
      chk($sformatf("%s_e%0d", tag, i),
          va, ev(is_set && i < 4, !is_set && i < 4, i == 1 || i == 2, i < 4, i == 4, 1'b0));
      if (noise && i == 0) begin
        if (is_set) ifa.clr_req = 1'b1;
        else        ifa.set_req = 1'b1;
      end
      if (noise && i == 3) begin
        ifa.set_req = 1'b0;
        ifa.clr_req = 1'b0;
      end
    end
    bad_fb = 1'b0;
  endtask

  initial begin
    ifa.set_req = 1'b1;
    ifa.clr_req = 1'b0;
    ifb.set_req = 1'b0;
    ifb.clr_req = 1'b0;

    // Reset holds everything low even with a request present and clocks running.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", va, 7'b0);
    chk("reset_b", vb, 7'b0);
    ifa.set_req = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("idle_after_reset", va, 7'b0);

    // Basic set at default timing.
    run_cmd("set", 1'b1, 1'b0, 1'b0);

    // Simultaneous requests: one-cycle conflict, nothing driven.
    ifa.set_req = 1'b1;
    ifa.clr_req = 1'b1;
    tick();
    chk("conflict_e0", va, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    ifa.set_req = 1'b0;
    ifa.clr_req = 1'b0;
    tick();
    chk("conflict_e1", va, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // clr_req while busy with a set is ignored.
    run_cmd("set_noise", 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the pulse.
    ifa.set_req = 1'b1;
    tick();
    ifa.set_req = 1'b0;
    chk("rst_mid_e0", va, ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("rst_mid_e1", va, ev(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    #2 rst = 1'b1;
    exp_err = 1'b0;
    #1;
    chk("rst_mid_async", va, 7'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_released", va, 7'b0);
    run_cmd("post_rst_set", 1'b1, 1'b0, 1'b0);

    // Readback: good clear, set with bad feedback, then a good clear.
    run_cmd("clear", 1'b0, 1'b0, 1'b0);
    run_cmd("bad_set", 1'b1, 1'b0, 1'b1);
    run_cmd("good_clear", 1'b0, 1'b0, 1'b0);

    // dut2 (3/1/2) with set_req held: a command every 7 edges.
    ifb.set_req = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      tick();
      if (i == 20) ifb.set_req = 1'b0;
      chk($sformatf("rep_e%0d", i), vb,
          {i % 7 < 6, 1'b0, i % 7 == 3, i % 7 < 6, i % 7 == 6, 1'b0, 1'b0});
    end
    tick();
    chk("rep_idle", vb, 7'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles S/R are held stable before en rises (legal range 1..15).
REQ-002 SHALL have parameter PULSE_CYC, default 2: cycles en is high (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles S/R are held stable after en falls (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port set_req, input, 1 bit: request to set the downstream gated SR latch.
REQ-007 SHALL have port clr_req, input, 1 bit: request to clear the downstream gated SR latch.
REQ-008 SHALL have port q_fb, input, 1 bit: q of the downstream latch, fed back.
REQ-009 SHALL have ports s, r, en, outputs, 1 bit each: the registered drive to the latch s, r and en inputs.
REQ-010 SHALL have port busy, output, 1 bit: a command is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-012 SHALL have port conflict, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-013 SHALL have port err, output, 1 bit: sticky latch-readback mismatch flag.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, PULSE and HOLD, using a 4-bit down-counter for phase length.
REQ-015 SHALL sample set_req and clr_req only in IDLE, and SHALL ignore both while busy=1 (no queuing).
REQ-016 SHALL, on sampling exactly one request at edge k, at that same edge set s=1 (set) or r=1 (clear), set busy=1 and enter SETUP.
REQ-017 SHALL set en=1 at edge k+SETUP_CYC (PULSE) and en=0 at edge k+SETUP_CYC+PULSE_CYC (HOLD).
REQ-018 SHALL, at edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC, clear s, r and busy, pulse done=1 for one cycle and return to IDLE.
REQ-019 SHALL accept a new request at the edge after done (back-to-back period = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles).
REQ-020 SHALL never assert s and r together, and SHALL change s and r only while en=0.
REQ-021 SHALL, when set_req=1 and clr_req=1 are sampled together in IDLE, execute neither request, pulse conflict=1 for one cycle and stay in IDLE.
REQ-022 SHALL treat requests as levels: a request still high in IDLE after done starts a new command.

Reset
REQ-023 SHALL, while rst=1, force s=0, r=0, en=0, busy=0, done=0, conflict=0, err=0 and state IDLE, independent of clk.
REQ-024 SHALL, on reset mid-command, abort the command immediately with no done pulse, leaving the latch in an indeterminate-but-undriven state (en=0).
REQ-025 SHALL allow the first request to be sampled at the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL use macro SR_DRV_VERIFY_EN to control latch readback checking.
REQ-027 SHALL, with SR_DRV_VERIFY_EN defined, sample q_fb at the done edge and set err=1 if q_fb differs from the commanded value (1 for set, 0 for clear), with err held until rst.
REQ-028 SHALL, without SR_DRV_VERIFY_EN, keep port q_fb present but unused and tie err to 0.

Verification
REQ-029 SHALL be covered by this scenario (default parameters): set_req pulse at edge 0 -> s=1 at edges 0–3; en=1 at edges 1–2; done=1 and s=0 at edge 4; busy high for exactly 4 cycles.
REQ-030 SHALL be covered by this scenario: set_req=1 and clr_req=1 together in IDLE -> conflict pulse of 1 cycle; s, r, en and busy stay 0.
REQ-031 SHALL be covered by this scenario: clr_req while busy from a set -> ignored; only one done pulse; r never asserted.
REQ-032 SHALL be covered by this scenario: rst asserted while en=1 (mid-PULSE) -> s, r, en and busy drop to 0 asynchronously with no done pulse; a set_req after release runs normally.
REQ-033 SHALL be covered by this scenario: with SR_DRV_VERIFY_EN and a latch model, set then clear -> err stays 0; with q_fb forced to 0 during a set -> err=1 at done and still 1 after a subsequent good command.
REQ-034 SHALL be covered by this scenario: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 with set_req held high -> en high 1 cycle per command; commands repeat every 7 cycles; an assertion checks s&r==0 and no s/r change while en=1.
